ee201_2048_board_reader: RTL and testbench
==========================================

EE201_2048_BOARD_READER -- requirements
Module: ee201_2048_board_reader

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WIN_EXP, 11, exponent code at or above which Win asserts (cell value 1024).
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- ClkPort  in  1  single system clock; all state on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Snap  in  1  one-cycle request to capture and stream the board.
- GB_flat  in  176  board; cell (x,y) at bits [(y*4+x)*11 +: 11], x = column 0..3, y = row 0..3.
- Busy  out  1  capture/stream/finish in progress.
- Cell_Valid  out  1  cell record presented.
- Cell_Ready  in  1  consumer accepts the record.
- Cell_Idx  out  4  cell index y*4+x.
- Cell_Exp  out  4  exponent code of the cell.
- Cell_Bad  out  1  cell value is not 0 and not a power of two.
- Done  out  1  one-cycle pulse; summary outputs valid.
- Max_Exp  out  4  largest valid exponent code on the board.
- Empty_Cnt  out  5  number of zero cells, 0..16.
- Can_Move  out  1  at least one legal move exists.
- Win  out  1  Max_Exp >= WIN_EXP.

Function
REQ-003 The exponent code SHALL be: value 0 -> 0; value 2^k for k = 0..10 -> k+1; any other value -> 15 with Cell_Bad = 1.
REQ-004 The state machine SHALL have the states IDLE, STREAM and FINISH.
REQ-005 In IDLE with Snap = 1, the block SHALL latch GB_flat into an internal snapshot, set the index to 0, clear the summary outputs, and enter STREAM on the same edge.
REQ-006 Snap SHALL be ignored in STREAM and FINISH.
REQ-007 GB_flat changes after capture SHALL NOT affect streamed records or summaries.
REQ-008 In STREAM, Cell_Valid SHALL be 1, and Cell_Idx/Cell_Exp/Cell_Bad SHALL describe the snapshot cell at the current index.
REQ-009 A transfer SHALL occur on an edge where Cell_Valid = 1 and Cell_Ready = 1; the index SHALL then advance by 1.
REQ-010 While Cell_Valid = 1 and Cell_Ready = 0, Cell_Idx, Cell_Exp and Cell_Bad SHALL hold stable.
REQ-011 The transfer of index 15 SHALL move the FSM to FINISH; the index SHALL NOT wrap to 0 within a scan.
REQ-012 FINISH SHALL last exactly one cycle with Done = 1 and Cell_Valid = 0, then return to IDLE.
REQ-013 From the FINISH cycle onward, Max_Exp, Empty_Cnt, Can_Move and Win SHALL hold the snapshot results until the next accepted Snap.
REQ-014 Max_Exp SHALL exclude bad cells (code 15); it SHALL be 0 on an all-zero board.
REQ-015 Can_Move SHALL be 1 if Empty_Cnt > 0, or if any horizontally or vertically adjacent pair of nonzero, non-bad cells has equal values; otherwise 0.
REQ-016 Busy SHALL be 1 in STREAM and FINISH, and 0 in IDLE.
REQ-017 Timing with Cell_Ready held at 1 and Snap at cycle t:
- records for index 0..15 in cycles t+1..t+16;
- Done in cycle t+17;
- Busy = 0 in cycle t+18.
REQ-018 Done and Cell_Valid SHALL never be 1 in the same cycle.
REQ-019 Cell_Valid SHALL be 0 outside STREAM.

Reset
REQ-020 Reset_n = 0 SHALL immediately, without waiting for a clock edge, force:
- FSM to IDLE and index to 0;
- snapshot to zero;
- Busy, Cell_Valid, Done, Can_Move and Win to 0;
- Cell_Idx, Cell_Exp, Cell_Bad, Max_Exp and Empty_Cnt to 0.
REQ-021 Reset asserted mid-stream SHALL abort the scan with no Done pulse; the first Snap after deassertion SHALL start a fresh scan from index 0.

Verification
REQ-022 The bench SHALL cover, one line each:
- Board all zero, Snap, Ready = 1 -> 16 records with Cell_Exp = 0; Done at t+17; Empty_Cnt = 16, Max_Exp = 0, Can_Move = 1, Win = 0.
- Cell (2,1) = 1024, others 0 -> the Idx 6 record has Cell_Exp = 11; Max_Exp = 11, Win = 1, Empty_Cnt = 15.
- Full checkerboard of 1 and 2, no equal neighbours -> Empty_Cnt = 0, Can_Move = 0, Max_Exp = 2.
- Same board with cell (0,0) = 2 and cell (1,0) = 2 -> Can_Move = 1.
- Cell 5 = 11'd6, Ready held 0 for 3 cycles at Idx 5 -> record held stable, Cell_Exp = 15, Cell_Bad = 1, Max_Exp excludes it; Snap during the stall is ignored.
- Reset_n pulled low at Idx 9 -> outputs zero asynchronously, no Done; next Snap streams from Idx 0 with fresh values.

Source files
------------

// File: rtl/ee201_2048_board_reader.sv
// ============================================================================
// Module   : ee201_2048_board_reader
// Brief    : Captures a 4x4 2048 board, streams per-cell exponent records over
//            a valid/ready handshake, then publishes board summary results.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ee201_2048_board_reader #(
    parameter int WIN_EXP = 11
) (
    input  logic         ClkPort,
    input  logic         Reset_n,
    input  logic         Snap,
    input  logic [175:0] GB_flat,
    output logic         Busy,
    output logic         Cell_Valid,
    input  logic         Cell_Ready,
    output logic [3:0]   Cell_Idx,
    output logic [3:0]   Cell_Exp,
    output logic         Cell_Bad,
    output logic         Done,
    output logic [3:0]   Max_Exp,
    output logic [4:0]   Empty_Cnt,
    output logic         Can_Move,
    output logic         Win
);

    localparam logic [3:0] WIN_CODE = 4'(WIN_EXP);
    localparam logic [3:0] BAD_CODE = 4'd15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [175:0]   snap_q, snap_d;
    logic [3:0]     idx_q, idx_d;
    logic [3:0]     max_q, max_d;
    logic [4:0]     empty_q, empty_d;
    logic           move_q, move_d;
    logic           win_q, win_d;

    logic [3:0]     code [16];
    logic [3:0]     scan_max;
    logic [4:0]     scan_empty;
    logic           scan_pair;
    logic [3:0]     cur_code;

    // 0 -> 0, 2^k -> k+1, anything else is flagged with the bad code
    function automatic logic [3:0] exp_code(input logic [10:0] v);
        logic [3:0] c;
        c = BAD_CODE;
        if (v == 11'd0) begin
            c = 4'd0;
        end else if ((v & (v - 11'd1)) == 11'd0) begin
            for (int k = 0; k < 11; k++) begin
                if (v[k]) c = 4'(k + 1);
            end
        end
        return c;
    endfunction

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            code[i] = exp_code(snap_q[i*11 +: 11]);
        end
    end

    // Equal codes among non-zero, non-bad cells means equal tile values
    always_comb begin
        scan_max   = 4'd0;
        scan_empty = 5'd0;
        scan_pair  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (code[i] != BAD_CODE && code[i] > scan_max) scan_max = code[i];
            if (code[i] == 4'd0) scan_empty = scan_empty + 5'd1;
        end
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 3; x++) begin
                if (code[y*4+x] != 4'd0 && code[y*4+x] != BAD_CODE &&
                    code[y*4+x] == code[y*4+x+1]) scan_pair = 1'b1;
            end
        end
        for (int y = 0; y < 3; y++) begin
            for (int x = 0; x < 4; x++) begin
                if (code[y*4+x] != 4'd0 && code[y*4+x] != BAD_CODE &&
                    code[y*4+x] == code[y*4+x+4]) scan_pair = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        max_d   = max_q;
        empty_d = empty_q;
        move_d  = move_q;
        win_d   = win_q;
        case (state_q)
            IDLE: begin
                if (Snap) begin
                    snap_d  = GB_flat;
                    idx_d   = 4'd0;
                    max_d   = 4'd0;
                    empty_d = 5'd0;
                    move_d  = 1'b0;
                    win_d   = 1'b0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (Cell_Ready) begin
                    if (idx_q == 4'd15) begin
                        max_d   = scan_max;
                        empty_d = scan_empty;
                        move_d  = (scan_empty != 5'd0) || scan_pair;
                        win_d   = (scan_max >= WIN_CODE);
                        state_d = FINISH;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            FINISH: begin
                idx_d   = 4'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            snap_q  <= '0;
            idx_q   <= 4'd0;
            max_q   <= 4'd0;
            empty_q <= 5'd0;
            move_q  <= 1'b0;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
            max_q   <= max_d;
            empty_q <= empty_d;
            move_q  <= move_d;
            win_q   <= win_d;
        end
    end

    assign cur_code   = code[idx_q];
    assign Cell_Valid = (state_q == STREAM);
    assign Cell_Idx   = Cell_Valid ? idx_q : 4'd0;
    assign Cell_Exp   = Cell_Valid ? cur_code : 4'd0;
    assign Cell_Bad   = Cell_Valid && (cur_code == BAD_CODE);
    assign Done       = (state_q == FINISH);
    assign Busy       = (state_q != IDLE);
    assign Max_Exp    = max_q;
    assign Empty_Cnt  = empty_q;
    assign Can_Move   = move_q;
    assign Win        = win_q;

endmodule

`default_nettype wire

// File: tb/tb_ee201_2048_board_reader.sv
// ============================================================================
// Module   : tb_ee201_2048_board_reader
// Brief    : Self-checking bench: behavioural board model plus directed scans.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ee201_2048_board_reader;

    logic         ClkPort;
    logic         Reset_n;
    logic         Snap;
    logic [175:0] GB_flat;
    logic         Busy;
    logic         Cell_Valid;
    logic         Cell_Ready;
    logic [3:0]   Cell_Idx;
    logic [3:0]   Cell_Exp;
    logic         Cell_Bad;
    logic         Done;
    logic [3:0]   Max_Exp;
    logic [4:0]   Empty_Cnt;
    logic         Can_Move;
    logic         Win;

    ee201_2048_board_reader #(.WIN_EXP(11)) dut (
        .ClkPort    (ClkPort),
        .Reset_n    (Reset_n),
        .Snap       (Snap),
        .GB_flat    (GB_flat),
        .Busy       (Busy),
        .Cell_Valid (Cell_Valid),
        .Cell_Ready (Cell_Ready),
        .Cell_Idx   (Cell_Idx),
        .Cell_Exp   (Cell_Exp),
        .Cell_Bad   (Cell_Bad),
        .Done       (Done),
        .Max_Exp    (Max_Exp),
        .Empty_Cnt  (Empty_Cnt),
        .Can_Move   (Can_Move),
        .Win        (Win)
    );

    initial begin
        ClkPort = 1'b0;
        forever #5 ClkPort = ~ClkPort;
    end

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int m_phase;          // 0 idle, 1 streaming, 2 finishing
    int m_pos;
    int m_code [16];
    int m_max, m_empty, m_move, m_win;
    int p_max, p_empty, p_move, p_win;

    function automatic int ref_code(input int v);
        if (v == 0) return 0;
        for (int k = 0; k <= 10; k++) if (v == (1 << k)) return k + 1;
        return 15;
    endfunction

    function automatic bit is_tile(input int v);
        return (v != 0) && (ref_code(v) != 15);
    endfunction

    task automatic model_capture(input logic [175:0] b);
        int vals [16];
        for (int i = 0; i < 16; i++) begin
            vals[i]   = int'(b[i*11 +: 11]);
            m_code[i] = ref_code(vals[i]);
        end
        p_max = 0; p_empty = 0; p_move = 0;
        for (int i = 0; i < 16; i++) begin
            if (vals[i] == 0) p_empty++;
            if (m_code[i] != 15 && m_code[i] > p_max) p_max = m_code[i];
        end
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++) begin
                if (x < 3 && is_tile(vals[y*4+x]) && vals[y*4+x] == vals[y*4+x+1]) p_move = 1;
                if (y < 3 && is_tile(vals[y*4+x]) && vals[y*4+x] == vals[y*4+x+4]) p_move = 1;
            end
        if (p_empty > 0) p_move = 1;
        p_win   = (p_max >= 11) ? 1 : 0;
        m_max = 0; m_empty = 0; m_move = 0; m_win = 0;
        m_pos   = 0;
        m_phase = 1;
    endtask

    always @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n) begin
            m_phase = 0; m_pos = 0;
            m_max = 0; m_empty = 0; m_move = 0; m_win = 0;
        end else begin
            case (m_phase)
                0: if (Snap) model_capture(GB_flat);
                1: if (Cell_Ready) begin
                       if (m_pos == 15) begin
                           m_phase = 2;
                           m_max = p_max; m_empty = p_empty; m_move = p_move; m_win = p_win;
                       end else begin
                           m_pos++;
                       end
                   end
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge ClkPort) begin
        if (chk_en) begin
            check("busy",  int'(Busy),       int'(m_phase != 0));
            check("valid", int'(Cell_Valid), int'(m_phase == 1));
            check("done",  int'(Done),       int'(m_phase == 2));
            if (m_phase == 1) begin
                check("cell_idx", int'(Cell_Idx), m_pos);
                check("cell_exp", int'(Cell_Exp), m_code[m_pos]);
                check("cell_bad", int'(Cell_Bad), int'(m_code[m_pos] == 15));
            end
            check("max_exp",   int'(Max_Exp),   m_max);
            check("empty_cnt", int'(Empty_Cnt), m_empty);
            check("can_move",  int'(Can_Move),  m_move);
            check("win",       int'(Win),       m_win);
        end
    end

    // ---------------- stimulus helpers ----------------
    int seen_exp [16];
    int seen_bad [16];

    function automatic logic [175:0] rand_board();
        logic [175:0] b;
        logic [10:0]  v;
        int r;
        b = '0;
        for (int i = 0; i < 16; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 35)      v = 11'd0;
            else if (r < 85) v = 11'(1 << $urandom_range(0, 3));
            else if (r < 95) v = 11'(1 << $urandom_range(0, 10));
            else             v = 11'($urandom_range(0, 2047));
            b[i*11 +: 11] = v;
        end
        return b;
    endfunction

    function automatic logic [175:0] put(input logic [175:0] b, input int idx, input int v);
        logic [175:0] r;
        r = b;
        r[idx*11 +: 11] = 11'(v);
        return r;
    endfunction

    // Snap at cycle t; done_cyc counts cycles after t until Done is seen
    task automatic do_scan(input logic [175:0] board, input int stall_idx, input int stall_len,
                           input bit snap_in_stall, output int done_cyc, output int busy_after);
        int stalls;
        stalls   = 0;
        done_cyc = -1;
        busy_after = -1;
        for (int i = 0; i < 16; i++) begin seen_exp[i] = -1; seen_bad[i] = -1; end
        @(negedge ClkPort); #1;
        GB_flat = board; Snap = 1'b1; Cell_Ready = 1'b1;
        @(negedge ClkPort); #1;
        Snap = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            GB_flat = rand_board();
            if (Done) begin done_cyc = n; break; end
            if (Cell_Valid) begin
                seen_exp[Cell_Idx] = int'(Cell_Exp);
                seen_bad[Cell_Idx] = int'(Cell_Bad);
                if (int'(Cell_Idx) == stall_idx && stalls < stall_len) begin
                    stalls++;
                    Cell_Ready = 1'b0;
                    Snap = snap_in_stall && (stalls == 2);
                end else begin
                    Cell_Ready = 1'b1;
                    Snap = 1'b0;
                end
            end
            @(negedge ClkPort); #1;
        end
        Snap = 1'b0; Cell_Ready = 1'b1;
        @(negedge ClkPort); #1;
        busy_after = int'(Busy);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int dc, ba, all0, found;
        logic [175:0] b;

        Reset_n = 1'b1; Snap = 1'b0; Cell_Ready = 1'b0; GB_flat = '0;
        #3 Reset_n = 1'b0;
        #1;
        check("rst_busy",  int'(Busy), 0);
        check("rst_valid", int'(Cell_Valid), 0);
        check("rst_done",  int'(Done), 0);
        check("rst_empty", int'(Empty_Cnt), 0);
        check("rst_move",  int'(Can_Move), 0);
        repeat (2) @(negedge ClkPort);
        #1 Reset_n = 1'b1;
        chk_en = 1'b1;

        check("ref_code_0",    ref_code(0), 0);
        check("ref_code_1",    ref_code(1), 1);
        check("ref_code_1024", ref_code(1024), 11);
        check("ref_code_6",    ref_code(6), 15);

        // all-zero board
        do_scan('0, -1, 0, 1'b0, dc, ba);
        check("zero_done_cycle", dc, 17);
        check("zero_busy_after", ba, 0);
        all0 = 1;
        for (int i = 0; i < 16; i++) if (seen_exp[i] != 0) all0 = 0;
        check("zero_all_exp0", all0, 1);
        check("zero_empty", int'(Empty_Cnt), 16);
        check("zero_max",   int'(Max_Exp), 0);
        check("zero_move",  int'(Can_Move), 1);
        check("zero_win",   int'(Win), 0);

        // single 1024 tile at (2,1)
        do_scan(put('0, 6, 1024), -1, 0, 1'b0, dc, ba);
        check("win_done_cycle", dc, 17);
        check("win_idx6_exp", seen_exp[6], 11);
        check("win_max",   int'(Max_Exp), 11);
        check("win_win",   int'(Win), 1);
        check("win_empty", int'(Empty_Cnt), 15);

        // checkerboard of 1 and 2
        b = '0;
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++)
                b = put(b, y*4 + x, ((x + y) % 2 == 1) ? 2 : 1);
        do_scan(b, -1, 0, 1'b0, dc, ba);
        check("chk_empty", int'(Empty_Cnt), 0);
        check("chk_move",  int'(Can_Move), 0);
        check("chk_max",   int'(Max_Exp), 2);

        b = put(put(b, 0, 2), 1, 2);
        do_scan(b, -1, 0, 1'b0, dc, ba);
        check("chk2_move", int'(Can_Move), 1);

        // bad cell with stall and ignored Snap
        do_scan(put(put('0, 0, 4), 5, 6), 5, 3, 1'b1, dc, ba);
        check("bad_done_cycle", dc, 20);
        check("bad_exp5", seen_exp[5], 15);
        check("bad_bad5", seen_bad[5], 1);
        check("bad_max",  int'(Max_Exp), 3);
        check("bad_empty", int'(Empty_Cnt), 14);

        // reset mid-stream at index 9
        @(negedge ClkPort); #1;
        GB_flat = rand_board(); Snap = 1'b1; Cell_Ready = 1'b1;
        @(negedge ClkPort); #1;
        Snap = 1'b0;
        found = 0;
        for (int n = 0; n < 30; n++) begin
            if (Cell_Valid && Cell_Idx == 4'd9) begin found = 1; break; end
            @(negedge ClkPort); #1;
        end
        check("rst_reach_idx9", found, 1);
        #2 Reset_n = 1'b0;
        #1;
        check("arst_busy",  int'(Busy), 0);
        check("arst_valid", int'(Cell_Valid), 0);
        check("arst_done",  int'(Done), 0);
        check("arst_idx",   int'(Cell_Idx), 0);
        check("arst_exp",   int'(Cell_Exp), 0);
        check("arst_bad",   int'(Cell_Bad), 0);
        check("arst_max",   int'(Max_Exp), 0);
        check("arst_empty", int'(Empty_Cnt), 0);
        check("arst_move",  int'(Can_Move), 0);
        check("arst_win",   int'(Win), 0);
        repeat (2) @(negedge ClkPort);
        #1 Reset_n = 1'b1;
        do_scan(put(put(put('0, 0, 2), 1, 2), 15, 512), -1, 0, 1'b0, dc, ba);
        check("post_rst_done_cycle", dc, 17);
        check("post_rst_exp0",  seen_exp[0], 2);
        check("post_rst_exp15", seen_exp[15], 10);
        check("post_rst_max",   int'(Max_Exp), 10);
        check("post_rst_empty", int'(Empty_Cnt), 13);
        check("post_rst_move",  int'(Can_Move), 1);

        // randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            @(negedge ClkPort); #1;
            Snap       = ($urandom_range(0, 5) == 0);
            Cell_Ready = ($urandom_range(0, 3) != 0);
            GB_flat    = rand_board();
        end
        Snap = 1'b0; Cell_Ready = 1'b1;
        repeat (25) @(negedge ClkPort);
        #1;
        check("drain_idle", int'(Busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
